// File: rtl/uart_tx_axis_fifo_if.sv
// AXI4-Stream byte/word channel feeding the UART transmitter.
// The master drives data and valid; the slave returns ready.
interface uart_tx_axis_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_tx_axis_fifo.sv
// UART transmitter with an AXI4-Stream input, an elastic FIFO and per-frame latched config.
// Frame: start, DATA_WIDTH data bits LSB first, optional parity, one or two stop bits.
//
// state  | meaning
// IDLE   | line high; pops the FIFO head and starts a frame when non-empty
// START  | start bit (low) for one bit period
// DATA   | DATA_WIDTH data bits, LSB first
// PARITY | parity bit (even or odd) for one bit period
// STOP   | line high for one or two bit periods
module uart_tx_axis_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PRESCALE_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_tx_axis_fifo_if.slave            s_axis,
    input  logic [PRESCALE_W-1:0]         prescale,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop2,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = PRESCALE_W + 3;
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [LW-1:0] FULL     = LW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [LW-1:0]         level, level_nxt;
    logic                  ready, push, pop;

    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BW-1:0]         bit_idx;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  par_en_q, par_bit_q, stop2_q, second_stop;
    logic                  tick, shift, txd_nxt;

    // Reload value for the bit timer: max(p,1)*8 - 1 clocks.
    function automatic logic [CW-1:0] bit_len(input logic [PRESCALE_W-1:0] p);
        logic [CW-1:0] e;
        e = (p == '0) ? CW'(1) : CW'(p);
        return (e << 3) - CW'(1);
    endfunction

    assign s_axis.tready = ready;
    assign push          = s_axis.tvalid && ready;
    assign fifo_level    = level;
    assign busy          = (level != '0) || (state != IDLE);
    assign tick          = (cnt == '0);

    always_comb begin
        level_nxt = level;
        if (push && !pop)
            level_nxt = level + LW'(1);
        else if (!push && pop)
            level_nxt = level - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s_axis.tdata;
    end

    // Ready is registered from the next occupancy so it never depends on tvalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ready  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            ready <= (level_nxt != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (level != '0) state_nxt = START;
            START:   if (tick) state_nxt = DATA;
            DATA:    if (tick && bit_idx == LAST_BIT) state_nxt = par_en_q ? PARITY : STOP;
            PARITY:  if (tick) state_nxt = STOP;
            STOP:    if (tick && (second_stop || !stop2_q)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        shift   = 1'b0;
        txd_nxt = txd;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    pop     = 1'b1;
                    txd_nxt = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    txd_nxt = shreg[0];
                    shift   = 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == LAST_BIT) begin
                        txd_nxt = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        txd_nxt = shreg[0];
                        shift   = 1'b1;
                    end
                end
            end
            PARITY:  if (tick) txd_nxt = 1'b1;
            STOP:    txd_nxt = 1'b1;
            default: txd_nxt = 1'b1;
        endcase
    end

    // Config is captured at pop so mid-frame changes only affect the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            txd         <= 1'b1;
            cnt         <= '0;
            shreg       <= '0;
            bit_idx     <= '0;
            prescale_q  <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            stop2_q     <= 1'b0;
            second_stop <= 1'b0;
        end else begin
            txd <= txd_nxt;
            if (pop) begin
                shreg      <= mem[rd_ptr];
                prescale_q <= prescale;
                par_en_q   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                par_bit_q  <= (^mem[rd_ptr]) ^ (parity_mode == 2'b10);
                stop2_q    <= stop2;
                cnt        <= bit_len(prescale);
            end else if (state != IDLE) begin
                cnt <= tick ? bit_len(prescale_q) : cnt - CW'(1);
            end
            if (shift)
                shreg <= shreg >> 1;
            if (state == START)
                bit_idx <= '0;
            else if (state == DATA && tick)
                bit_idx <= bit_idx + BW'(1);
            if (state != STOP)
                second_stop <= 1'b0;
            else if (tick)
                second_stop <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_axis_fifo.sv
// Bench for uart_tx_axis_fifo: a waveform-expanding reference model checked every cycle,
// plus directed frames with hand-computed bit values and timings.
module tb_uart_tx_axis_fifo;
    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] prescale;
    logic [1:0]    parity_mode;
    logic          stop2;
    logic          txd;
    logic          busy;
    logic [4:0]    fifo_level;

    uart_tx_axis_fifo_if #(.DATA_WIDTH(DW)) axis ();

    uart_tx_axis_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PRESCALE_W(PW)) dut (
        .clk(clk),
        .rst(rst),
        .s_axis(axis),
        .prescale(prescale),
        .parity_mode(parity_mode),
        .stop2(stop2),
        .txd(txd),
        .busy(busy),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int ntests = 0;
    int nfail = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: accepted words queue, and the expected txd value per clock.
    bit [DW-1:0] mq[$];
    bit          wave[$];
    bit          m_txd = 1'b1;
    bit          m_rdy = 1'b0;
    bit          do_push;

    task automatic build_frame(input bit [DW-1:0] w);
        int len;
        bit bits[$];
        len = ((prescale == 0) ? 1 : int'(prescale)) * 8;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(w[i]);
        if (parity_mode == 2'b01) bits.push_back(^w);
        else if (parity_mode == 2'b10) bits.push_back(~^w);
        bits.push_back(1'b1);
        if (stop2) bits.push_back(1'b1);
        foreach (bits[j]) repeat (len) wave.push_back(bits[j]);
        wave.push_back(1'b1);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            wave.delete();
            m_txd = 1'b1;
            m_rdy = 1'b0;
        end else begin
            do_push = axis.tvalid && m_rdy;
            if (wave.size() == 0 && mq.size() != 0) build_frame(mq.pop_front());
            if (wave.size() != 0) m_txd = wave.pop_front();
            else m_txd = 1'b1;
            if (do_push) mq.push_back(axis.tdata);
            m_rdy = (mq.size() != DEPTH);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            ntests++;
            if (txd !== m_txd || busy !== (wave.size() != 0 || mq.size() != 0) ||
                fifo_level !== 5'(mq.size()) || axis.tready !== m_rdy) begin
                nfail++;
                $display("FAIL model_cmp cyc=%0d txd=%b/%b busy=%b/%b level=%0d/%0d tready=%b/%b (got/exp)",
                         cyc, txd, m_txd, busy, (wave.size() != 0 || mq.size() != 0),
                         fifo_level, mq.size(), axis.tready, m_rdy);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 0);
    endtask

    task automatic send_one(input bit [DW-1:0] w, output int k);
        check("send_ready", axis.tready, 1);
        axis.tdata  = w;
        axis.tvalid = 1'b1;
        @(negedge clk);
        k = cyc;
        axis.tvalid = 1'b0;
    endtask

    bit e55[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int k, i, first_block, cycles;
    bit stable, rdy_s, acc;

    initial begin
        rst = 1'b1;
        axis.tvalid = 1'b0;
        axis.tdata = '0;
        prescale = 16'd1;
        parity_mode = 2'b00;
        stop2 = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_tready", axis.tready, 0);
        check("rst_txd", txd, 1);
        check("rst_level", fifo_level, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("tready_after_rst", axis.tready, 1);

        stable = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (axis.tready !== 1'b1 || fifo_level !== 5'd0 || txd !== 1'b1 || busy !== 1'b0) stable = 1'b0;
        end
        check("ready_stable_idle", stable, 1);

        // Basic 8N1 frame of 0x55 at 8 clocks per bit.
        send_one(8'h55, k);
        for (int b = 0; b < 10; b++) begin
            wait_cyc(k + 1 + 8 * b + 4);
            check($sformatf("basic_bit%0d", b), txd, e55[b]);
        end
        wait_cyc(k + 80);
        check("basic_busy_last_stop", busy, 1);
        wait_cyc(k + 81);
        check("basic_busy_fall", busy, 0);

        // Even parity with two stop bits: 12 periods, 96 clocks.
        parity_mode = 2'b01;
        stop2 = 1'b1;
        send_one(8'hA3, k);
        wait_cyc(k + 77);
        check("even_parity_bit", txd, 0);
        wait_cyc(k + 96);
        check("even_busy_end", busy, 1);
        wait_cyc(k + 97);
        check("even_busy_fall", busy, 0);

        parity_mode = 2'b10;
        stop2 = 1'b0;
        send_one(8'hA3, k);
        wait_cyc(k + 77);
        check("odd_parity_bit", txd, 1);
        wait_idle("odd_idle", 200);

        // Config latch: two 0x0F frames; parity/stop2 change during the first.
        parity_mode = 2'b00;
        stop2 = 1'b0;
        axis.tdata = 8'h0F;
        axis.tvalid = 1'b1;
        @(negedge clk);
        k = cyc;
        @(negedge clk);
        axis.tvalid = 1'b0;
        wait_cyc(k + 20);
        parity_mode = 2'b01;
        stop2 = 1'b1;
        wait_cyc(k + 77);
        check("latch_first_stop_not_parity", txd, 1);
        wait_cyc(k + 81);
        check("latch_idle_gap_txd", txd, 1);
        wait_cyc(k + 82 + 72 + 4);
        check("latch_second_parity", txd, 0);
        wait_cyc(k + 177);
        check("latch_second_busy_end", busy, 1);
        wait_cyc(k + 178);
        check("latch_second_busy_fall", busy, 0);

        // Fill / backpressure: 20 incrementing words, tvalid held high.
        parity_mode = 2'b00;
        stop2 = 1'b0;
        prescale = 16'd100;
        i = 0;
        first_block = -1;
        cycles = 0;
        axis.tvalid = 1'b1;
        while (i < 20 && cycles < 20000) begin
            axis.tdata = 8'(i);
            rdy_s = axis.tready;
            @(negedge clk);
            cycles++;
            if (rdy_s) i++;
            if (axis.tready === 1'b0 && first_block < 0) begin
                first_block = i;
                check("fill_level_at_block", fifo_level, 16);
                check("fill_accepted_before_block", first_block, 17);
                prescale = 16'd2;
            end
        end
        axis.tvalid = 1'b0;
        check("fill_all_accepted", i, 20);
        wait_idle("fill_drain", 12000);

        // Randomised traffic with occasional config changes.
        acc = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            if (!axis.tvalid || acc) begin
                axis.tvalid = ($urandom_range(0, 2) != 0);
                axis.tdata = 8'($urandom);
            end
            if ($urandom_range(0, 60) == 0) begin
                prescale = 16'($urandom_range(0, 2));
                parity_mode = 2'($urandom);
                stop2 = 1'($urandom);
            end
            rdy_s = axis.tready;
            @(negedge clk);
            acc = rdy_s && axis.tvalid;
        end
        axis.tvalid = 1'b0;
        wait_idle("random_drain", 5000);

        // Reset during data bit 3 with five words queued.
        prescale = 16'd1;
        parity_mode = 2'b00;
        stop2 = 1'b0;
        axis.tvalid = 1'b1;
        for (int w = 0; w < 6; w++) begin
            axis.tdata = 8'(8'hC0 + w);
            @(negedge clk);
            if (w == 0) k = cyc;
        end
        axis.tvalid = 1'b0;
        wait_cyc(k + 35);
        check("pre_rst_level", fifo_level, 5);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_txd", txd, 1);
        check("midrst_level", fifo_level, 0);
        check("midrst_busy", busy, 0);
        check("midrst_tready", axis.tready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_tready", axis.tready, 1);
        stable = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) stable = 1'b0;
        end
        check("post_rst_no_residue", stable, 1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
